// File: rtl/id_ex_hazard_stage_pkg.sv
// rtl/id_ex_hazard_stage_pkg.sv - shared pipeline types for the ID/EX stage
package id_ex_hazard_stage_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_REG_W  = 5;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic {
        ST_RUN,
        ST_BUBBLE
    } hz_state_t;

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_BUBBLE,
        ACT_HOLD
    } id_ex_action_t;

endpackage

// File: rtl/id_ex_hazard_stage_load_use_detect.sv
// rtl/id_ex_hazard_stage_load_use_detect.sv - combinational load-use hazard equation
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             hz
);

    // A load targeting $0 produces nothing to wait for.
    assign hz = ex_mem_read && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/id_ex_hazard_stage.sv
// rtl/id_ex_hazard_stage.sv - ID/EX pipeline register with load-use stall, flush and hold
module id_ex_hazard_stage
    import id_ex_hazard_stage_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int REG_W  = DEFAULT_REG_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  ID_Rs,
    input  logic [REG_W-1:0]  ID_Rt,
    input  logic [REG_W-1:0]  ID_Rd,
    input  logic              ID_UsesRt,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_SignImm,
    input  logic              ID_RegWrite,
    input  logic              ID_MemtoReg,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_ALUSrc,
    input  logic              ID_RegDst,
    input  logic [1:0]        ID_ALUOp,
    input  logic              Flush,
    input  logic              Hold,
    output logic [REG_W-1:0]  ID_EX_Rs,
    output logic [REG_W-1:0]  ID_EX_Rt,
    output logic [REG_W-1:0]  ID_EX_Rd,
    output logic [DATA_W-1:0] ID_EX_ReadData1,
    output logic [DATA_W-1:0] ID_EX_ReadData2,
    output logic [DATA_W-1:0] ID_EX_SignImm,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemtoReg,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic              ID_EX_ALUSrc,
    output logic              ID_EX_RegDst,
    output logic [1:0]        ID_EX_ALUOp,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              LoadUseStall,
    output logic [CNT_W-1:0]  bubble_count,
    output logic [CNT_W-1:0]  flush_count
);

    id_ex_ctrl_t   ctrl_q;
    id_ex_ctrl_t   id_ctrl;
    hz_state_t     state, next_state;
    id_ex_action_t action;
    logic          hz;
    logic          flush_evt;
    logic          bubble_evt;

    assign id_ctrl = '{reg_write: ID_RegWrite, mem_to_reg: ID_MemtoReg, mem_read: ID_MemRead,
                       mem_write: ID_MemWrite, alu_src: ID_ALUSrc, reg_dst: ID_RegDst,
                       alu_op: ID_ALUOp};

    load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rt       (ID_EX_Rt),
        .id_rs       (ID_Rs),
        .id_rt       (ID_Rt),
        .id_uses_rt  (ID_UsesRt),
        .hz          (hz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Reset forces the idle handshake so upstream never sees a stall while cleared.
    always_comb begin
        next_state   = ST_RUN;
        action       = ACT_LOAD;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        LoadUseStall = 1'b0;
        flush_evt    = 1'b0;
        bubble_evt   = 1'b0;
        if (reset) begin
            next_state = state;
            action     = ACT_HOLD;
        end else if (Flush) begin
            action    = ACT_BUBBLE;
            flush_evt = 1'b1;
        end else if (Hold) begin
            next_state  = state;
            action      = ACT_HOLD;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
        end else if (hz && state == ST_RUN) begin
            next_state   = ST_BUBBLE;
            action       = ACT_BUBBLE;
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            LoadUseStall = 1'b1;
            bubble_evt   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q          <= CTRL_BUBBLE;
            ID_EX_Rs        <= '0;
            ID_EX_Rt        <= '0;
            ID_EX_Rd        <= '0;
            ID_EX_ReadData1 <= '0;
            ID_EX_ReadData2 <= '0;
            ID_EX_SignImm   <= '0;
        end else if (action == ACT_LOAD) begin
            ctrl_q          <= id_ctrl;
            ID_EX_Rs        <= ID_Rs;
            ID_EX_Rt        <= ID_Rt;
            ID_EX_Rd        <= ID_Rd;
            ID_EX_ReadData1 <= ID_ReadData1;
            ID_EX_ReadData2 <= ID_ReadData2;
            ID_EX_SignImm   <= ID_SignImm;
        end else if (action == ACT_BUBBLE) begin
            ctrl_q          <= CTRL_BUBBLE;
            ID_EX_Rs        <= '0;
            ID_EX_Rt        <= '0;
            ID_EX_Rd        <= '0;
            ID_EX_ReadData1 <= '0;
            ID_EX_ReadData2 <= '0;
            ID_EX_SignImm   <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (bubble_evt) bubble_count <= bubble_count + CNT_W'(1);
            if (flush_evt)  flush_count  <= flush_count + CNT_W'(1);
        end
    end

    assign ID_EX_RegWrite = ctrl_q.reg_write;
    assign ID_EX_MemtoReg = ctrl_q.mem_to_reg;
    assign ID_EX_MemRead  = ctrl_q.mem_read;
    assign ID_EX_MemWrite = ctrl_q.mem_write;
    assign ID_EX_ALUSrc   = ctrl_q.alu_src;
    assign ID_EX_RegDst   = ctrl_q.reg_dst;
    assign ID_EX_ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// tb/tb_id_ex_hazard_stage.sv - self-checking bench for id_ex_hazard_stage
module tb_id_ex_hazard_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        id_uses_rt = 1'b0;
    logic [31:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0;
    logic        id_regwrite = 1'b0, id_memtoreg = 1'b0, id_memread = 1'b0;
    logic        id_memwrite = 1'b0, id_alusrc = 1'b0, id_regdst = 1'b0;
    logic [1:0]  id_aluop = '0;
    logic        flush = 1'b0, hold = 1'b0;

    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rd1, ex_rd2, ex_imm;
    logic        ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc, ex_regdst;
    logic [1:0]  ex_aluop;
    logic        pc_write, if_id_write, load_use_stall;
    logic [3:0]  bubble_count, flush_count;

    logic [118:0] id_vec, ex_vec;
    logic [118:0] m_ex;
    int           m_b, m_f;
    int           checks = 0;
    int           errors = 0;

    assign id_vec = {id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm, id_regwrite, id_memtoreg,
                     id_memread, id_memwrite, id_alusrc, id_regdst, id_aluop};
    assign ex_vec = {ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_regwrite, ex_memtoreg,
                     ex_memread, ex_memwrite, ex_alusrc, ex_regdst, ex_aluop};

    id_ex_hazard_stage #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_Rd(id_rd), .ID_UsesRt(id_uses_rt),
        .ID_ReadData1(id_rd1), .ID_ReadData2(id_rd2), .ID_SignImm(id_imm),
        .ID_RegWrite(id_regwrite), .ID_MemtoReg(id_memtoreg), .ID_MemRead(id_memread),
        .ID_MemWrite(id_memwrite), .ID_ALUSrc(id_alusrc), .ID_RegDst(id_regdst),
        .ID_ALUOp(id_aluop), .Flush(flush), .Hold(hold),
        .ID_EX_Rs(ex_rs), .ID_EX_Rt(ex_rt), .ID_EX_Rd(ex_rd),
        .ID_EX_ReadData1(ex_rd1), .ID_EX_ReadData2(ex_rd2), .ID_EX_SignImm(ex_imm),
        .ID_EX_RegWrite(ex_regwrite), .ID_EX_MemtoReg(ex_memtoreg), .ID_EX_MemRead(ex_memread),
        .ID_EX_MemWrite(ex_memwrite), .ID_EX_ALUSrc(ex_alusrc), .ID_EX_RegDst(ex_regdst),
        .ID_EX_ALUOp(ex_aluop), .PCWrite(pc_write), .IF_ID_Write(if_id_write),
        .LoadUseStall(load_use_stall), .bubble_count(bubble_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Reference: the instruction held in ID/EX and the two event tallies.
    function automatic logic model_hz();
        logic [4:0] rt;
        rt = m_ex[113:109];
        return m_ex[5] && rt != 0 && (rt == id_rs || (id_uses_rt && rt == id_rt));
    endfunction

    task automatic tick();
        logic hz;
        hz = model_hz();
        @(posedge clk);
        if (flush) begin
            m_ex = '0;
            m_f++;
        end else if (!hold) begin
            if (hz) begin
                m_ex = '0;
                m_b++;
            end else begin
                m_ex = id_vec;
            end
        end
        #1;
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                             input logic is_load);
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = 5'($urandom_range(1, 31));
        id_uses_rt  = uses_rt;
        id_rd1      = $urandom;
        id_rd2      = $urandom;
        id_imm      = $urandom;
        id_regwrite = 1'b1;
        id_memtoreg = is_load;
        id_memread  = is_load;
        id_memwrite = 1'b0;
        id_alusrc   = is_load;
        id_regdst   = !is_load;
        id_aluop    = is_load ? 2'd0 : 2'd2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        hold  = 1'b0;
        set_instr(5'd0, 5'd0, 1'b0, 1'b0);
        m_ex = '0;
        m_b  = 0;
        m_f  = 0;
        #4;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hold  = 1'b1;
        #3;
        checks++;
        if (ex_vec !== '0) begin errors++; $display("FAIL reset_ex: got %h expected 0", ex_vec); end
        checks++;
        if ({pc_write, if_id_write, load_use_stall} !== 3'b110) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 110", {pc_write, if_id_write, load_use_stall});
        end
        checks++;
        if (bubble_count !== 0 || flush_count !== 0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", bubble_count, flush_count);
        end
        do_reset();
    endtask

    task automatic test_load_use_rs();
        do_reset();
        set_instr(5'd1, 5'd8, 1'b0, 1'b1);
        tick();
        set_instr(5'd8, 5'd3, 1'b0, 1'b0);
        #1;
        checks++;
        if (pc_write !== 1'b0 || if_id_write !== 1'b0 || load_use_stall !== 1'b1) begin
            errors++; $display("FAIL lu_rs_stall: got %b%b%b expected 001", pc_write, if_id_write, load_use_stall);
        end
        tick();
        checks++;
        if (ex_memread !== 1'b0 || ex_regwrite !== 1'b0 || bubble_count !== 4'd1) begin
            errors++; $display("FAIL lu_rs_bubble: got mr=%b rw=%b bc=%0d expected 0 0 1", ex_memread, ex_regwrite, bubble_count);
        end
        checks++;
        if (pc_write !== 1'b1 || load_use_stall !== 1'b0) begin
            errors++; $display("FAIL lu_rs_once: got pcw=%b lus=%b expected 1 0", pc_write, load_use_stall);
        end
        tick();
        checks++;
        if (ex_rs !== 5'd8 || ex_vec !== m_ex) begin
            errors++; $display("FAIL lu_rs_reload: got rs=%0d expected 8", ex_rs);
        end
    endtask

    task automatic test_rt_gating();
        do_reset();
        set_instr(5'd2, 5'd9, 1'b0, 1'b1);
        tick();
        set_instr(5'd4, 5'd9, 1'b0, 1'b0);
        #1;
        checks++;
        if (load_use_stall !== 1'b0 || pc_write !== 1'b1) begin
            errors++; $display("FAIL rt_unused: got lus=%b expected 0", load_use_stall);
        end
        id_uses_rt = 1'b1;
        #1;
        checks++;
        if (load_use_stall !== 1'b1 || pc_write !== 1'b0) begin
            errors++; $display("FAIL rt_used: got lus=%b expected 1", load_use_stall);
        end
        do_reset();
        set_instr(5'd2, 5'd0, 1'b0, 1'b1);
        tick();
        set_instr(5'd0, 5'd0, 1'b1, 1'b0);
        #1;
        checks++;
        if (load_use_stall !== 1'b0 || pc_write !== 1'b1) begin
            errors++; $display("FAIL rt_zero: got lus=%b expected 0", load_use_stall);
        end
    endtask

    task automatic test_flush_hazard();
        do_reset();
        set_instr(5'd1, 5'd8, 1'b0, 1'b1);
        tick();
        set_instr(5'd8, 5'd8, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        checks++;
        if (pc_write !== 1'b1 || load_use_stall !== 1'b0) begin
            errors++; $display("FAIL fh_ctrl: got pcw=%b lus=%b expected 1 0", pc_write, load_use_stall);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (ex_vec !== '0 || flush_count !== 4'd1 || bubble_count !== 4'd0) begin
            errors++; $display("FAIL fh_result: got fc=%0d bc=%0d expected 1 0", flush_count, bubble_count);
        end
        tick();
        checks++;
        if (ex_rs !== 5'd8 || bubble_count !== 4'd0) begin
            errors++; $display("FAIL fh_run: got rs=%0d bc=%0d expected 8 0", ex_rs, bubble_count);
        end
    endtask

    task automatic test_hold_hz();
        logic [118:0] held;
        do_reset();
        set_instr(5'd1, 5'd8, 1'b0, 1'b1);
        tick();
        held = m_ex;
        set_instr(5'd8, 5'd2, 1'b0, 1'b0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (pc_write !== 1'b0 || if_id_write !== 1'b0 || load_use_stall !== 1'b0) begin
                errors++; $display("FAIL hold_ctrl[%0d]: got %b%b%b expected 000", i, pc_write, if_id_write, load_use_stall);
            end
            tick();
            checks++;
            if (ex_vec !== held || bubble_count !== 0 || flush_count !== 0) begin
                errors++; $display("FAIL hold_keep[%0d]: got %h expected %h", i, ex_vec, held);
            end
        end
        hold = 1'b0;
        #1;
        checks++;
        if (load_use_stall !== 1'b1) begin errors++; $display("FAIL hold_release: got lus=%b expected 1", load_use_stall); end
        tick();
        checks++;
        if (ex_memread !== 1'b0 || bubble_count !== 4'd1 || load_use_stall !== 1'b0) begin
            errors++; $display("FAIL hold_bubble: got mr=%b bc=%0d lus=%b expected 0 1 0", ex_memread, bubble_count, load_use_stall);
        end
    endtask

    task automatic test_reset_mid_bubble();
        do_reset();
        set_instr(5'd1, 5'd8, 1'b0, 1'b1);
        tick();
        set_instr(5'd8, 5'd2, 1'b0, 1'b0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_instr(5'd3, 5'd8, 1'b0, 1'b1);
        tick();
        #2;
        reset = 1'b1;
        hold  = 1'b1;
        #1;
        checks++;
        if (ex_vec !== '0 || pc_write !== 1'b1 || bubble_count !== 0 || flush_count !== 0) begin
            errors++; $display("FAIL async_reset: got ex=%h pcw=%b bc=%0d fc=%0d expected 0 1 0 0", ex_vec, pc_write, bubble_count, flush_count);
        end
        do_reset();
        set_instr(5'd1, 5'd8, 1'b0, 1'b1);
        tick();
        set_instr(5'd8, 5'd3, 1'b1, 1'b0);
        #1;
        checks++;
        if (load_use_stall !== 1'b1) begin errors++; $display("FAIL post_reset_stall: got %b expected 1", load_use_stall); end
        tick();
        tick();
        checks++;
        if (bubble_count !== 4'd1 || ex_rs !== 5'd8) begin
            errors++; $display("FAIL post_reset_once: got bc=%0d rs=%0d expected 1 8", bubble_count, ex_rs);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_instr(5'd1, 5'd5, 1'b0, 1'b1);
            tick();
            set_instr(5'd5, 5'd6, 1'b1, 1'b0);
            tick();
            tick();
        end
        checks++;
        if (bubble_count !== 4'd1) begin errors++; $display("FAIL counter_wrap: got %0d expected 1", bubble_count); end
    endtask

    task automatic test_random();
        logic exp_pcw, exp_lus, hz;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                      1'($urandom_range(0, 1)));
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 6) == 0);
            #1;
            hz      = model_hz();
            exp_pcw = flush || !(hold || hz);
            exp_lus = !flush && !hold && hz;
            checks++;
            if (pc_write !== exp_pcw || if_id_write !== exp_pcw || load_use_stall !== exp_lus) begin
                errors++; $display("FAIL rand_comb[%0d]: got %b%b%b expected %b%b%b", i, pc_write, if_id_write, load_use_stall, exp_pcw, exp_pcw, exp_lus);
            end
            tick();
            checks++;
            if (ex_vec !== m_ex || bubble_count !== 4'(m_b) || flush_count !== 4'(m_f)) begin
                errors++; $display("FAIL rand_reg[%0d]: got %h bc=%0d fc=%0d expected %h bc=%0d fc=%0d", i, ex_vec, bubble_count, flush_count, m_ex, 4'(m_b), 4'(m_f));
            end
        end
        flush = 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use_rs();
        test_rt_gating();
        test_flush_hazard();
        test_hold_hz();
        test_reset_mid_bubble();
        test_counter_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
